// File: rtl/mont_precompute_pkg.sv
// Shared definitions for the Montgomery constant precompute stage:
// operand width default, FSM state encoding and counter sizing.
package mont_precompute_pkg;

    localparam int BITS_DEFAULT = 578;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Iteration counter must index 0..bits-1; never narrower than one bit.
    function automatic int cnt_width(input int bits);
        return (bits > 1) ? $clog2(bits) : 1;
    endfunction

endpackage

// File: rtl/mont_precompute_mod_double.sv
// Combinational modular doubling: y = 2x mod n, assuming x < n so that
// 2x fits in BITS+1 bits and a single conditional subtract suffices.
module mod_double
    import mont_precompute_pkg::*;
#(
    parameter int BITS = BITS_DEFAULT
) (
    input  logic [BITS:0]   x,
    input  logic [BITS-1:0] n,
    output logic [BITS:0]   y
);

    logic [BITS:0] dbl_s;
    logic [BITS:0] n_ext_s;

    assign dbl_s   = x << 1;
    assign n_ext_s = {1'b0, n};

    // Single conditional subtraction brings 2x back into [0, n).
    always_comb begin
        y = dbl_s;
        if (dbl_s >= n_ext_s) begin
            y = dbl_s - n_ext_s;
        end else begin
            y = dbl_s;
        end
    end

endmodule

// File: rtl/mont_precompute.sv
// Computes base*R mod N, R mod N and -N^-1 mod R (R = 2^BITS) for the
// exponentiation ladder, one doubling/lifting iteration per clock.
module mont_precompute
    import mont_precompute_pkg::*;
#(
    parameter int BITS = BITS_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [BITS-1:0] base,
    input  logic [BITS-1:0] N,
    output logic            busy,
    output logic            finish,
    output logic            err,
    output logic [BITS-1:0] base_mont,
    output logic [BITS-1:0] one_mont,
    output logic [BITS-1:0] N_prime
);

    localparam int CW = cnt_width(BITS);

    state_t          state_r, state_s;
    logic [BITS-1:0] base_r, base_s;
    logic [BITS-1:0] n_r, n_s;
    logic [BITS:0]   a_r, a_s;
    logic [BITS:0]   o_r, o_s;
    logic [BITS:0]   u_r, u_s;
    logic [BITS-1:0] y_r, y_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic            busy_s, finish_s, err_s;
    logic [BITS-1:0] base_mont_s, one_mont_s, n_prime_s;

    logic [BITS:0]   a_dbl_s, o_dbl_s;
    logic [BITS+1:0] u_sum_s;
    logic [BITS:0]   u_lift_s;
    logic [BITS-1:0] y_bit_s, y_lift_s;
    logic            bad_s;

    mod_double #(.BITS(BITS)) u_dbl_a (.x(a_r), .n(n_r), .y(a_dbl_s));
    mod_double #(.BITS(BITS)) u_dbl_o (.x(o_r), .n(n_r), .y(o_dbl_s));

    // Hensel-style lifting: if u is odd, add N so the halving is exact and
    // record a one in the corresponding bit of N_prime.
    assign u_sum_s  = {1'b0, u_r} + {2'b00, n_r};
    assign u_lift_s = u_r[0] ? (BITS+1)'(u_sum_s >> 1) : (u_r >> 1);
    assign y_bit_s  = BITS'(1) << cnt_r;
    assign y_lift_s = u_r[0] ? (y_r | y_bit_s) : y_r;

    assign bad_s = ~n_r[0] | (n_r <= BITS'(1)) | (base_r >= n_r);

    // Next-state and next-value logic for the whole datapath.
    always_comb begin
        state_s     = state_r;
        base_s      = base_r;
        n_s         = n_r;
        a_s         = a_r;
        o_s         = o_r;
        u_s         = u_r;
        y_s         = y_r;
        cnt_s       = cnt_r;
        busy_s      = busy;
        finish_s    = 1'b0;
        err_s       = err;
        base_mont_s = base_mont;
        one_mont_s  = one_mont;
        n_prime_s   = N_prime;
        case (state_r)
            IDLE: begin
                if (start) begin
                    base_s  = base;
                    n_s     = N;
                    busy_s  = 1'b1;
                    state_s = CHECK;
                end else begin
                    busy_s  = 1'b0;
                end
            end
            CHECK: begin
                if (bad_s) begin
                    state_s     = DONE;
                    finish_s    = 1'b1;
                    err_s       = 1'b1;
                    base_mont_s = {BITS{1'b0}};
                    one_mont_s  = {BITS{1'b0}};
                    n_prime_s   = {BITS{1'b0}};
                end else begin
                    a_s     = {1'b0, base_r};
                    o_s     = (BITS+1)'(1);
                    u_s     = (BITS+1)'(1);
                    y_s     = {BITS{1'b0}};
                    cnt_s   = {CW{1'b0}};
                    state_s = RUN;
                end
            end
            RUN: begin
                a_s   = a_dbl_s;
                o_s   = o_dbl_s;
                u_s   = u_lift_s;
                y_s   = y_lift_s;
                cnt_s = cnt_r + CW'(1);
                // Outputs are registered on the final iteration so they are
                // already valid in the DONE cycle alongside finish.
                if (cnt_r == CW'(BITS-1)) begin
                    state_s     = DONE;
                    finish_s    = 1'b1;
                    err_s       = 1'b0;
                    base_mont_s = a_dbl_s[BITS-1:0];
                    one_mont_s  = o_dbl_s[BITS-1:0];
                    n_prime_s   = y_lift_s;
                end else begin
                    state_s     = RUN;
                end
            end
            DONE: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State, working and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            base_r    <= {BITS{1'b0}};
            n_r       <= {BITS{1'b0}};
            a_r       <= {(BITS+1){1'b0}};
            o_r       <= {(BITS+1){1'b0}};
            u_r       <= {(BITS+1){1'b0}};
            y_r       <= {BITS{1'b0}};
            cnt_r     <= {CW{1'b0}};
            busy      <= 1'b0;
            finish    <= 1'b0;
            err       <= 1'b0;
            base_mont <= {BITS{1'b0}};
            one_mont  <= {BITS{1'b0}};
            N_prime   <= {BITS{1'b0}};
        end else begin
            state_r   <= state_s;
            base_r    <= base_s;
            n_r       <= n_s;
            a_r       <= a_s;
            o_r       <= o_s;
            u_r       <= u_s;
            y_r       <= y_s;
            cnt_r     <= cnt_s;
            busy      <= busy_s;
            finish    <= finish_s;
            err       <= err_s;
            base_mont <= base_mont_s;
            one_mont  <= one_mont_s;
            N_prime   <= n_prime_s;
        end
    end

endmodule

// File: tb/tb_mont_precompute.sv
// Self-checking bench for mont_precompute at BITS=8: directed vector table,
// multi-cycle corner sequences and random requests against an arithmetic model.
module tb_mont_precompute;

    localparam int BITS = 8;
    localparam int R    = 1 << BITS;

    logic            clk;
    logic            rst;
    logic            start;
    logic [BITS-1:0] base;
    logic [BITS-1:0] N;
    logic            busy, finish, err;
    logic [BITS-1:0] base_mont, one_mont, N_prime;

    int checks   = 0;
    int failures = 0;

    int prev_bm = 0, prev_om = 0, prev_np = 0, prev_err = 0;

    typedef struct {
        int n;
        int b;
        int e_err;
        int e_bm;
        int e_om;
        int e_np;
    } vec_t;

    vec_t vecs[7];

    mont_precompute #(.BITS(BITS)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .N(N),
        .busy(busy), .finish(finish), .err(err),
        .base_mont(base_mont), .one_mont(one_mont), .N_prime(N_prime)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference built straight from the definitions of the three constants.
    task automatic model(input int n, input int b, output int e, output int bm,
                         output int om, output int np);
        e = ((n % 2) == 0 || n <= 1 || b >= n) ? 1 : 0;
        bm = 0; om = 0; np = 0;
        if (e == 0) begin
            om = R % n;
            bm = (b * R) % n;
            for (int y = 0; y < R; y++) begin
                if (((n * y + 1) % R) == 0) np = y;
            end
        end
    endtask

    // One request: checks hold of old outputs while busy, latency, results, pulse width.
    task automatic run_req(input string tag, input int n, input int b, input int e_err,
                           input int e_bm, input int e_om, input int e_np);
        int edges;
        @(negedge clk);
        N = BITS'(n); base = BITS'(b); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, int'(busy), 1);
        check({tag, "_hold_bm"}, int'(base_mont), prev_bm);
        check({tag, "_hold_np"}, int'(N_prime), prev_np);
        edges = 1;
        while (!finish && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        check({tag, "_latency"}, edges, (e_err != 0) ? 2 : BITS + 2);
        check({tag, "_err"}, int'(err), e_err);
        check({tag, "_bm"}, int'(base_mont), e_bm);
        check({tag, "_om"}, int'(one_mont), e_om);
        check({tag, "_np"}, int'(N_prime), e_np);
        @(negedge clk);
        check({tag, "_pulse"}, int'(finish), 0);
        check({tag, "_busy_low"}, int'(busy), 0);
        check({tag, "_hold_after"}, int'(one_mont), e_om);
        prev_bm = e_bm; prev_om = e_om; prev_np = e_np; prev_err = e_err;
    endtask

    initial begin
        int e, bm, om, np, n, b, edges, fin_cnt;

        vecs[0] = '{13,   5, 0, 6, 9, 59};
        vecs[1] = '{255,  2, 0, 2, 1,  1};
        vecs[2] = '{13,   0, 0, 0, 9, 59};
        vecs[3] = '{12,   3, 1, 0, 0,  0};
        vecs[4] = '{13,  13, 1, 0, 0,  0};
        vecs[5] = '{1,    0, 1, 0, 0,  0};
        vecs[6] = '{3,    2, 0, 2, 1, 85};

        rst = 1'b0; start = 1'b0; base = '0; N = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_finish", int'(finish), 0);
        check("rst_err", int'(err), 0);
        check("rst_bm", int'(base_mont), 0);
        check("rst_np", int'(N_prime), 0);
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_req($sformatf("vec%0d", i), vecs[i].n, vecs[i].b, vecs[i].e_err,
                    vecs[i].e_bm, vecs[i].e_om, vecs[i].e_np);
        end

        // start pulses while busy must be ignored
        @(negedge clk);
        N = 8'd13; base = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 1; fin_cnt = 0;
        while (edges < 30) begin
            if (edges == 3 || edges == 5) begin
                N = 8'd3; base = 8'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            edges++;
            if (finish) begin
                fin_cnt++;
                if (fin_cnt == 1) begin
                    check("busy_start_lat", edges, BITS + 2);
                    check("busy_start_bm", int'(base_mont), 6);
                    check("busy_start_np", int'(N_prime), 59);
                end
            end
        end
        start = 1'b0;
        check("busy_start_single", fin_cnt, 1);
        check("busy_start_om_hold", int'(one_mont), 9);

        // reset in the middle of RUN
        @(negedge clk);
        N = 8'd3; base = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_bm", int'(base_mont), 0);
        check("midrst_om", int'(one_mont), 0);
        check("midrst_np", int'(N_prime), 0);
        fin_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (finish) fin_cnt++;
        end
        rst = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (finish) fin_cnt++;
        end
        check("midrst_no_finish", fin_cnt, 0);
        prev_bm = 0; prev_om = 0; prev_np = 0; prev_err = 0;
        run_req("post_rst", 13, 5, 0, 6, 9, 59);

        // random requests against the arithmetic model
        for (int k = 0; k < 25; k++) begin
            n = $urandom_range(0, 255);
            if (k % 4 != 0) n = n | 1;
            b = $urandom_range(0, 255);
            if (k % 5 != 0 && n > 0) b = b % n;
            model(n, b, e, bm, om, np);
            run_req($sformatf("rnd%0d", k), n, b, e, bm, om, np);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
